// File: rtl/adc_spi_capture.sv
// ----------------------------------------------------------------------------
// adc_spi_capture
//
// Periodically (or on demand) reads one conversion frame from an SPI ADC
// (CPOL=0, data sampled on the rising SCLK edge, MSB first). The result is
// taken from the last ADC_BITS bits of the frame. It is presented
// zero-extended on adcdata, together with a one-cycle valid pulse.
//
// Parameters
//   CLKDIV    clock cycles per SCLK half-period (1..255)
//   FRAME     SCLK cycles per frame (ADC_BITS..32)
//   ADC_BITS  result width (at least 2)
//   PERIOD    clock cycles between automatic conversion starts
//
// Ports
//   clock     sole clock, rising edge
//   reset     asynchronous reset, active low
//   enable    high = periodic conversions run
//   start     single-cycle request for an immediate conversion
//   adc_sdo   serial data from the ADC
//   adc_csn   ADC chip select, active low
//   adc_sclk  ADC serial clock, idles low
//   adcdata   last conversion result, zero-extended to 32 bits
//   valid     one-cycle pulse in the cycle adcdata takes a new value
//   busy      conversion in progress
//   overrun   sticky: a trigger arrived while busy and was dropped
// ----------------------------------------------------------------------------
module adc_spi_capture #(
    parameter int CLKDIV   = 2,
    parameter int FRAME    = 16,
    parameter int ADC_BITS = 12,
    parameter int PERIOD   = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic        adc_sdo,
    output logic        adc_csn,
    output logic        adc_sclk,
    output logic [31:0] adcdata,
    output logic        valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int HW = $clog2(2 * FRAME);
    localparam logic [7:0]    DIV_LAST    = 8'(CLKDIV - 1);
    localparam logic [HW-1:0] HALF_LAST   = HW'(2 * FRAME - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD - 1);

    state_t              state;
    state_t              next_state;
    logic [7:0]          div_cnt;
    logic [HW-1:0]       half_cnt;
    logic [PW-1:0]       period_cnt;
    logic                sclk_q;
    logic [ADC_BITS-1:0] shift_reg;

    logic phase_end;
    logic trigger;

    // phase_end marks the last cycle of a CLKDIV-long phase.
    // A start pulse and a period hit in the same cycle are one trigger.
    assign phase_end = (div_cnt == DIV_LAST);
    assign trigger   = start || (enable && (period_cnt == PERIOD_LAST));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. SHIFT lasts 2*FRAME phases, low first, so it ends
    // on a high phase and HOLD entry is the final falling SCLK edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (trigger) next_state = SETUP;
            SETUP:   if (phase_end) next_state = SHIFT;
            SHIFT:   if (phase_end && (half_cnt == HALF_LAST)) next_state = HOLD;
            HOLD:    if (phase_end) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from state only. Reset therefore forces the
    // chip select and SCLK to idle without waiting for a clock edge.
    always_comb begin
        adc_csn  = 1'b1;
        adc_sclk = 1'b0;
        valid    = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE:  busy = 1'b0;
            SETUP: adc_csn = 1'b0;
            SHIFT: begin
                adc_csn  = 1'b0;
                adc_sclk = sclk_q;
            end
            HOLD:  ;
            DONE:  valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // The free-running period counter only depends on enable, never on the
    // FSM. Dropping enable restarts the spacing from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
        end else if (!enable || (period_cnt == PERIOD_LAST)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    // Phase timing and SCLK generation. The edge that raises SCLK is also the
    // edge that samples adc_sdo. The ADC changes data after the falling edge,
    // so the bit is stable here. Only the last ADC_BITS bits survive.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt   <= '0;
            half_cnt  <= '0;
            sclk_q    <= 1'b0;
            shift_reg <= '0;
        end else begin
            if ((state == IDLE) || (state == DONE) || phase_end) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            if (state != SHIFT) begin
                half_cnt <= '0;
                sclk_q   <= 1'b0;
            end else if (phase_end) begin
                half_cnt <= half_cnt + HW'(1);
                sclk_q   <= ~sclk_q;
                if (!sclk_q) begin
                    shift_reg <= {shift_reg[ADC_BITS-2:0], adc_sdo};
                end
            end
        end
    end

    // The result is loaded on the HOLD->DONE edge, so it is already on
    // adcdata during the valid cycle. A frame cut short by reset never gets
    // this far. A trigger that lands while busy is lost and recorded.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            adcdata <= '0;
            overrun <= 1'b0;
        end else begin
            if ((state == HOLD) && phase_end) begin
                adcdata <= 32'(shift_reg);
            end
            if (trigger && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_capture.sv
// ----------------------------------------------------------------------------
// tb_adc_spi_capture
//
// Bench for adc_spi_capture. It uses two instances:
//   dut_a  default parameters, for start-driven conversions
//   dut_b  CLKDIV=1, PERIOD=100, for periodic conversions
// Each instance has an SPI ADC model that shifts out a 16-bit word MSB
// first. The model changes data after each falling SCLK edge.
// ----------------------------------------------------------------------------
module tb_adc_spi_capture;

    logic        clock = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;

    logic        rst_a = 1'b0, enable_a = 1'b0, start_a = 1'b0, sdo_a = 1'b0;
    logic        csn_a, sclk_a, valid_a, busy_a, overrun_a;
    logic [31:0] adcdata_a;

    logic        rst_b = 1'b0, enable_b = 1'b0, start_b = 1'b0, sdo_b = 1'b0;
    logic        csn_b, sclk_b, valid_b, busy_b, overrun_b;
    logic [31:0] adcdata_b;

    adc_spi_capture dut_a (
        .clock(clock), .reset(rst_a), .enable(enable_a), .start(start_a),
        .adc_sdo(sdo_a), .adc_csn(csn_a), .adc_sclk(sclk_a),
        .adcdata(adcdata_a), .valid(valid_a), .busy(busy_a), .overrun(overrun_a)
    );

    adc_spi_capture #(.CLKDIV(1), .PERIOD(100)) dut_b (
        .clock(clock), .reset(rst_b), .enable(enable_b), .start(start_b),
        .adc_sdo(sdo_b), .adc_csn(csn_b), .adc_sclk(sclk_b),
        .adcdata(adcdata_b), .valid(valid_b), .busy(busy_b), .overrun(overrun_b)
    );

    always #5 clock = ~clock;

    // cyc equals the number of rising edges seen so far.
    always @(posedge clock) cyc <= cyc + 1;

    // ADC models
    logic [15:0] word_a = 16'h0000;
    logic [15:0] word_b = 16'h0000;
    int          idx_a = 0, idx_b = 0;
    int          ramp_b = 1;

    always @(negedge csn_a) begin
        idx_a = 15;
        sdo_a = word_a[15];
    end
    always @(negedge sclk_a) begin
        if (idx_a > 0) begin
            idx_a = idx_a - 1;
            sdo_a = word_a[idx_a];
        end
    end

    always @(negedge csn_b) begin
        word_b = 16'(ramp_b);
        ramp_b = ramp_b + 1;
        idx_b  = 15;
        sdo_b  = word_b[15];
    end
    always @(negedge sclk_b) begin
        if (idx_b > 0) begin
            idx_b = idx_b - 1;
            sdo_b = word_b[idx_b];
        end
    end

    // Monitors, sampled on the falling clock edge
    int          vcnt_a = 0, vcyc_a = 0, csn_low_a = 0, rise_a = 0;
    logic        sclk_prev_a = 1'b0;
    int          vcnt_b = 0, csn_fall_b = 0;
    logic        csn_prev_b = 1'b1;
    int          vt_b [0:7];
    logic [31:0] vd_b [0:7];

    always @(negedge clock) begin
        if (valid_a) begin
            vcnt_a = vcnt_a + 1;
            vcyc_a = cyc;
        end
        if (!csn_a) csn_low_a = csn_low_a + 1;
        if (sclk_a && !sclk_prev_a) rise_a = rise_a + 1;
        sclk_prev_a = sclk_a;
        if (valid_b) begin
            if (vcnt_b < 8) begin
                vt_b[vcnt_b] = cyc;
                vd_b[vcnt_b] = adcdata_b;
            end
            vcnt_b = vcnt_b + 1;
        end
        if (!csn_b && csn_prev_b) csn_fall_b = cyc;
        csn_prev_b = csn_b;
    end

    task automatic clear_a();
        vcnt_a = 0; vcyc_a = 0; csn_low_a = 0; rise_a = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (csn_a !== 1'b1) $display("[TB] FAIL reset_csn got %b want 1", csn_a); else passed++;
        checks++; if (sclk_a !== 1'b0) $display("[TB] FAIL reset_sclk got %b want 0", sclk_a); else passed++;
        checks++; if (adcdata_a !== 32'h0) $display("[TB] FAIL reset_adcdata got %h want 0", adcdata_a); else passed++;
        checks++; if (valid_a !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", valid_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy_a); else passed++;
        checks++; if (overrun_a !== 1'b0) $display("[TB] FAIL reset_overrun got %b want 0", overrun_a); else passed++;
        @(posedge clock); #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        clear_a();
        word_a  = 16'h0ABC;
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        for (int i = 0; i < 200 && rise_a < 8; i++) begin
            @(negedge clock); #2;
        end
        checks++; if (rise_a !== 8) $display("[TB] FAIL midreset_reach_edge8 got %0d want 8", rise_a); else passed++;
        // Mid-cycle, well away from any rising edge.
        rst_a = 1'b0;
        #1;
        checks++; if (csn_a !== 1'b1) $display("[TB] FAIL midreset_csn got %b want 1", csn_a); else passed++;
        checks++; if (sclk_a !== 1'b0) $display("[TB] FAIL midreset_sclk got %b want 0", sclk_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("[TB] FAIL midreset_busy got %b want 0", busy_a); else passed++;
        @(posedge clock); #1;
        rst_a = 1'b1;
        repeat (80) @(posedge clock);
        #1;
        checks++; if (vcnt_a !== 0) $display("[TB] FAIL midreset_valid_count got %0d want 0", vcnt_a); else passed++;
        checks++; if (adcdata_a !== 32'h0) $display("[TB] FAIL midreset_adcdata got %h want 0", adcdata_a); else passed++;
    endtask

    task automatic test_single();
        int t0;
        clear_a();
        word_a  = 16'h0ABC;
        start_a = 1'b1;
        t0      = cyc;
        @(posedge clock); #1;
        start_a = 1'b0;
        repeat (80) @(posedge clock);
        #1;
        checks++; if (csn_low_a !== 66) $display("[TB] FAIL single_csn_low got %0d want 66", csn_low_a); else passed++;
        checks++; if (rise_a !== 16) $display("[TB] FAIL single_sclk_rises got %0d want 16", rise_a); else passed++;
        checks++; if (vcnt_a !== 1) $display("[TB] FAIL single_valid_count got %0d want 1", vcnt_a); else passed++;
        checks++; if (vcyc_a - t0 !== 69) $display("[TB] FAIL single_latency got %0d want 69", vcyc_a - t0); else passed++;
        checks++; if (adcdata_a !== 32'h00000ABC) $display("[TB] FAIL single_adcdata got %h want 00000abc", adcdata_a); else passed++;
        checks++; if (overrun_a !== 1'b0) $display("[TB] FAIL single_overrun got %b want 0", overrun_a); else passed++;
    endtask

    task automatic test_overrun();
        int t0;
        clear_a();
        word_a  = 16'h5123;
        start_a = 1'b1;
        t0      = cyc;
        @(posedge clock); #1;
        start_a = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        repeat (80) @(posedge clock);
        #1;
        checks++; if (vcnt_a !== 1) $display("[TB] FAIL overrun_valid_count got %0d want 1", vcnt_a); else passed++;
        checks++; if (vcyc_a - t0 !== 69) $display("[TB] FAIL overrun_latency got %0d want 69", vcyc_a - t0); else passed++;
        checks++; if (csn_low_a !== 66) $display("[TB] FAIL overrun_csn_low got %0d want 66", csn_low_a); else passed++;
        checks++; if (adcdata_a !== 32'h00000123) $display("[TB] FAIL overrun_adcdata got %h want 00000123", adcdata_a); else passed++;
        checks++; if (overrun_a !== 1'b1) $display("[TB] FAIL overrun_flag got %b want 1", overrun_a); else passed++;
    endtask

    task automatic test_all_ones();
        clear_a();
        word_a  = 16'hFFFF;
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        repeat (80) @(posedge clock);
        #1;
        checks++; if (vcnt_a !== 1) $display("[TB] FAIL ones_valid_count got %0d want 1", vcnt_a); else passed++;
        checks++; if (adcdata_a !== 32'h00000FFF) $display("[TB] FAIL ones_adcdata got %h want 00000fff", adcdata_a); else passed++;
    endtask

    // Enable raised right after edge R: the trigger is taken at edge R+100,
    // and DONE follows 34 edges later (conversion length 35 at CLKDIV=1).
    task automatic test_periodic();
        int r;
        vcnt_b   = 0;
        ramp_b   = 1;
        enable_b = 1'b1;
        r        = cyc;
        repeat (340) @(posedge clock);
        #1;
        enable_b = 1'b0;
        checks++; if (vcnt_b !== 3) $display("[TB] FAIL periodic_valid_count got %0d want 3", vcnt_b); else passed++;
        checks++; if (vt_b[0] - r !== 134) $display("[TB] FAIL periodic_first_valid got %0d want 134", vt_b[0] - r); else passed++;
        checks++; if (vt_b[1] - vt_b[0] !== 100) $display("[TB] FAIL periodic_spacing1 got %0d want 100", vt_b[1] - vt_b[0]); else passed++;
        checks++; if (vt_b[2] - vt_b[1] !== 100) $display("[TB] FAIL periodic_spacing2 got %0d want 100", vt_b[2] - vt_b[1]); else passed++;
        checks++; if (vd_b[0] !== 32'd1) $display("[TB] FAIL periodic_data1 got %h want 1", vd_b[0]); else passed++;
        checks++; if (vd_b[1] !== 32'd2) $display("[TB] FAIL periodic_data2 got %h want 2", vd_b[1]); else passed++;
        checks++; if (vd_b[2] !== 32'd3) $display("[TB] FAIL periodic_data3 got %h want 3", vd_b[2]); else passed++;
        checks++; if (overrun_b !== 1'b0) $display("[TB] FAIL periodic_overrun got %b want 0", overrun_b); else passed++;
    endtask

    task automatic test_enable_gap();
        int r3;
        repeat (20) @(posedge clock);
        #1;
        vcnt_b     = 0;
        csn_fall_b = 0;
        enable_b   = 1'b1;
        repeat (50) @(posedge clock);
        #1;
        enable_b = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        enable_b = 1'b1;
        r3       = cyc;
        repeat (140) @(posedge clock);
        #1;
        enable_b = 1'b0;
        checks++; if (vcnt_b !== 1) $display("[TB] FAIL gap_valid_count got %0d want 1", vcnt_b); else passed++;
        checks++; if (csn_fall_b - r3 !== 100) $display("[TB] FAIL gap_trigger_delay got %0d want 100", csn_fall_b - r3); else passed++;
        checks++; if (vt_b[0] - r3 !== 134) $display("[TB] FAIL gap_valid_delay got %0d want 134", vt_b[0] - r3); else passed++;
        checks++; if (vd_b[0] !== 32'd4) $display("[TB] FAIL gap_data got %h want 4", vd_b[0]); else passed++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_single();
        test_overrun();
        test_all_ones();
        test_periodic();
        test_enable_gap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
